hc74_seq_ctrl: RTL and testbench

//  Command-driven sequencer for one dual D flip-flop (HC74-style: D, CP, SDN, RDN, Q, QN per channel).

---
 rtl/hc74_seq_ctrl_if.sv | 23 ++
 rtl/hc74_seq_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_hc74_seq_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/hc74_seq_ctrl_if.sv
// Command/response bus between a requester and the HC74 sequencer.
// Carries a single-beat command and a one-cycle response strobe.
// master = requester side, slave = sequencer side.
interface hc74_seq_ctrl_if;
  logic       cmd_vld;
  logic       cmd_rdy;
  logic [1:0] cmd_op;
  logic       cmd_ch;
  logic       cmd_d;
  logic       rsp_vld;
  logic       rsp_q;
  logic       rsp_err;

  modport master (
    output cmd_vld, cmd_op, cmd_ch, cmd_d,
    input  cmd_rdy, rsp_vld, rsp_q, rsp_err
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_ch, cmd_d,
    output cmd_rdy, rsp_vld, rsp_q, rsp_err
  );
endinterface

// File: rtl/hc74_seq_ctrl.sv
// Sequencer turning WRITE/SET/CLEAR/READ commands into timed pin waveforms for one dual HC74 flip-flop.
// Latency: WRITE rsp at SETUP+PULSE+HOLD+1, SET/CLEAR at PULSE+HOLD+1, READ at 3 (+2 for WRITE/SET/CLEAR with HC74_CTRL_VERIFY_EN).
// Backpressure: cmd_rdy only in IDLE, one command outstanding, commands while busy are dropped; responses cannot be stalled.
// Optional feature macro: HC74_CTRL_VERIFY_EN (read back Q after WRITE/SET/CLEAR).
module hc74_seq_ctrl #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  hc74_seq_ctrl_if.slave       bus,
  output logic                 d1_o,
  output logic                 d2_o,
  output logic                 cp1_o,
  output logic                 cp2_o,
  output logic                 sd1n_o,
  output logic                 sd2n_o,
  output logic                 rd1n_o,
  output logic                 rd2n_o,
  input  logic                 q1_i,
  input  logic                 q1n_i,
  input  logic                 q2_i,
  input  logic                 q2n_i
);

  // The counter must also cover the fixed 2-cycle SAMPLE state.
  localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_B   = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
  localparam int MAX_CYC = (MAX_B > 2) ? MAX_B : 2;
  localparam int CNT_W   = $clog2(MAX_CYC);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_SAMPLE,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               ch_q, ch_d;
  logic               dat_q, dat_d;

  // Pin registers, index 0 = channel 1, index 1 = channel 2.
  logic [1:0]         d_q, d_d;
  logic [1:0]         cp_q, cp_d;
  logic [1:0]         sdn_q, sdn_d;
  logic [1:0]         rdn_q, rdn_d;

  logic               rsp_vld_q, rsp_vld_d;
  logic               rsp_q_q, rsp_q_d;
  logic               rsp_err_q, rsp_err_d;

  // Synchronizer bit layout: {q2n, q2, q1n, q1}.
  logic [3:0]         sync1_q, sync2_q;

  logic               q_syn;
  logic               qn_syn;
  logic               exp_q;

  // Two-flop synchronizers on the flip-flop outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= {q2n_i, q2_i, q1n_i, q1_i};
      sync2_q <= sync1_q;
    end
  end

  assign q_syn  = ch_q ? sync2_q[2] : sync2_q[0];
  assign qn_syn = ch_q ? sync2_q[3] : sync2_q[1];

  // Value Q should take after the command: written data, 1 for SET, 0 for CLEAR.
  assign exp_q  = (op_q == OP_WRITE) ? dat_q : (op_q == OP_SET);

  // State, counter, command capture and pin/response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_WRITE;
      ch_q      <= 1'b0;
      dat_q     <= 1'b0;
      d_q       <= 2'b00;
      cp_q      <= 2'b00;
      sdn_q     <= 2'b11;
      rdn_q     <= 2'b11;
      rsp_vld_q <= 1'b0;
      rsp_q_q   <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      ch_q      <= ch_d;
      dat_q     <= dat_d;
      d_q       <= d_d;
      cp_q      <= cp_d;
      sdn_q     <= sdn_d;
      rdn_q     <= rdn_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_q_q   <= rsp_q_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Next-state and next pin values; pins change on the edge that enters each state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    ch_d      = ch_q;
    dat_d     = dat_q;
    d_d       = d_q;
    cp_d      = cp_q;
    sdn_d     = sdn_q;
    rdn_d     = rdn_q;
    rsp_vld_d = 1'b0;
    rsp_q_d   = rsp_q_q;
    rsp_err_d = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_vld) begin
          op_d  = bus.cmd_op;
          ch_d  = bus.cmd_ch;
          dat_d = bus.cmd_d;
          cnt_d = '0;
          case (bus.cmd_op)
            OP_WRITE: begin
              d_d[bus.cmd_ch] = bus.cmd_d;
              state_d         = S_SETUP;
            end
            OP_SET: begin
              sdn_d[bus.cmd_ch] = 1'b0;
              state_d           = S_PULSE;
            end
            OP_CLEAR: begin
              rdn_d[bus.cmd_ch] = 1'b0;
              state_d           = S_PULSE;
            end
            default: begin
              state_d = S_SAMPLE;
            end
          endcase
        end
      end

      S_SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          cnt_d      = '0;
          cp_d[ch_q] = 1'b1;
          state_d    = S_PULSE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_PULSE: begin
        if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
          // Only the strobe this command asserted is active, so releasing all three is safe.
          cnt_d       = '0;
          cp_d[ch_q]  = 1'b0;
          sdn_d[ch_q] = 1'b1;
          rdn_d[ch_q] = 1'b1;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          cnt_d = '0;
`ifdef HC74_CTRL_VERIFY_EN
          state_d = S_SAMPLE;
`else
          state_d   = S_RESP;
          rsp_vld_d = 1'b1;
          rsp_q_d   = exp_q;
          rsp_err_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SAMPLE: begin
        // Two cycles lets the pin change reach the synchronizer output.
        if (cnt_q == CNT_W'(1)) begin
          cnt_d     = '0;
          state_d   = S_RESP;
          rsp_vld_d = 1'b1;
          rsp_q_d   = q_syn;
          rsp_err_d = (q_syn == qn_syn) | ((op_q != OP_READ) & (q_syn != exp_q));
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.cmd_rdy = (state_q == S_IDLE);
  assign bus.rsp_vld = rsp_vld_q;
  assign bus.rsp_q   = rsp_q_q;
  assign bus.rsp_err = rsp_err_q;

  assign d1_o   = d_q[0];
  assign d2_o   = d_q[1];
  assign cp1_o  = cp_q[0];
  assign cp2_o  = cp_q[1];
  assign sd1n_o = sdn_q[0];
  assign sd2n_o = sdn_q[1];
  assign rd1n_o = rdn_q[0];
  assign rd2n_o = rdn_q[1];

endmodule

// File: tb/tb_hc74_seq_ctrl.sv
// Directed bench for hc74_seq_ctrl with a behavioural HC74 model on the pins.
// Cycle k after acceptance is observed 1 time unit after the k-th clock edge.
// Model outputs can be overridden to create illegal or stuck readbacks.
module tb_hc74_seq_ctrl;

`ifdef HC74_CTRL_VERIFY_EN
  localparam int EXTRA = 2;
  localparam bit VFY   = 1'b1;
`else
  localparam int EXTRA = 0;
  localparam bit VFY   = 1'b0;
`endif
  localparam int LW = 6 + EXTRA;
  localparam int LS = 4 + EXTRA;
  localparam int LR = 3;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  logic clk = 1'b0;
  logic rst;
  logic d1, d2, cp1, cp2, sd1n, sd2n, rd1n, rd2n;
  logic q1, q1n, q2, q2n;

  logic m_q1   = 1'b0;
  logic m_q2   = 1'b0;
  logic bad1   = 1'b0;
  logic stuck1 = 1'b0;

  int n_vec = 0;
  int n_mis = 0;

  hc74_seq_ctrl_if bus_if ();

  hc74_seq_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus_if),
    .d1_o   (d1),
    .d2_o   (d2),
    .cp1_o  (cp1),
    .cp2_o  (cp2),
    .sd1n_o (sd1n),
    .sd2n_o (sd2n),
    .rd1n_o (rd1n),
    .rd2n_o (rd2n),
    .q1_i   (q1),
    .q1n_i  (q1n),
    .q2_i   (q2),
    .q2n_i  (q2n)
  );

  always #5 clk = ~clk;

  // HC74 behaviour: async set/clear dominate, else capture D on CP rise.
  always @(posedge cp1 or negedge sd1n or negedge rd1n) begin
    if (sd1n === 1'b0)      m_q1 <= 1'b1;
    else if (rd1n === 1'b0) m_q1 <= 1'b0;
    else if (cp1 === 1'b1)  m_q1 <= d1;
  end

  always @(posedge cp2 or negedge sd2n or negedge rd2n) begin
    if (sd2n === 1'b0)      m_q2 <= 1'b1;
    else if (rd2n === 1'b0) m_q2 <= 1'b0;
    else if (cp2 === 1'b1)  m_q2 <= d2;
  end

  assign q1  = bad1 ? 1'b0 : (stuck1 ? 1'b0 : m_q1);
  assign q1n = bad1 ? 1'b0 : (stuck1 ? 1'b1 : ~m_q1);
  assign q2  = m_q2;
  assign q2n = ~m_q2;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge; returns in cycle 1 of that command.
  task automatic send(input logic [1:0] op, input logic ch, input logic d);
    bus_if.cmd_op  = op;
    bus_if.cmd_ch  = ch;
    bus_if.cmd_d   = d;
    bus_if.cmd_vld = 1'b1;
    tick();
    bus_if.cmd_vld = 1'b0;
  endtask

  // Issue a command, find its response within a bounded window, check latency and payload.
  task automatic issue(input string tag, input logic [1:0] op, input logic ch, input logic d,
                       input int lat, input logic exp_q, input logic exp_err);
    int got;
    got = -1;
    send(op, ch, d);
    for (int c = 1; c <= lat + 4; c++) begin
      if (bus_if.rsp_vld === 1'b1 && got < 0) begin
        got = c;
        chk({tag, "_rsp_q"}, bus_if.rsp_q, exp_q);
        chk({tag, "_rsp_err"}, bus_if.rsp_err, exp_err);
      end
      tick();
    end
    chk({tag, "_lat"}, 8'(got), 8'(lat));
    chk({tag, "_rdy"}, bus_if.cmd_rdy, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus_if.cmd_vld = 1'b0;
    bus_if.cmd_op  = OP_WRITE;
    bus_if.cmd_ch  = 1'b0;
    bus_if.cmd_d   = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_d1",   d1, 1'b0);
    chk("rst_cp1",  cp1, 1'b0);
    chk("rst_sd1n", sd1n, 1'b1);
    chk("rst_rd1n", rd1n, 1'b1);
    chk("rst_d2",   d2, 1'b0);
    chk("rst_sd2n", sd2n, 1'b1);
    chk("rst_rsp_vld", bus_if.rsp_vld, 1'b0);
    chk("rst_rsp_q",   bus_if.rsp_q, 1'b0);
    chk("rst_rsp_err", bus_if.rsp_err, 1'b0);
    rst = 1'b0;
    tick();
    chk("rst_rdy", bus_if.cmd_rdy, 1'b1);

    // 1: WRITE ch1 D=1 waveform
    send(OP_WRITE, 1'b0, 1'b1);
    for (int c = 1; c <= LW; c++) begin
      chk("t1_d1", d1, 1'b1);
      chk("t1_cp1", cp1, (c == 3 || c == 4));
      chk("t1_cp2", cp2, 1'b0);
      chk("t1_rsp_vld", bus_if.rsp_vld, (c == LW));
      if (c == LW) begin
        chk("t1_rsp_q", bus_if.rsp_q, 1'b1);
        chk("t1_rsp_err", bus_if.rsp_err, 1'b0);
      end
      tick();
    end
    chk("t1_rdy", bus_if.cmd_rdy, 1'b1);
    chk("t1_d1_kept", d1, 1'b1);

    // 2: SET ch2, channel 1 pins untouched, then READ ch2
    send(OP_SET, 1'b1, 1'b0);
    for (int c = 1; c <= LS; c++) begin
      chk("t2_sd2n", sd2n, (c > 2));
      chk("t2_rd2n", rd2n, 1'b1);
      chk("t2_cp2", cp2, 1'b0);
      chk("t2_ch1", {4'b0, d1, cp1, sd1n, rd1n}, 8'b0000_1011);
      chk("t2_rsp_vld", bus_if.rsp_vld, (c == LS));
      if (c == LS) begin
        chk("t2_rsp_q", bus_if.rsp_q, 1'b1);
        chk("t2_rsp_err", bus_if.rsp_err, 1'b0);
      end
      tick();
    end
    issue("t2_read2", OP_READ, 1'b1, 1'b0, LR, 1'b1, 1'b0);
    chk("t2_ch1_after", {4'b0, d1, cp1, sd1n, rd1n}, 8'b0000_1011);

    // 3: CLEAR ch1 with an illegal Q1=Q1N=0 readback, then READ ch1
    bad1 = 1'b1;
    issue("t3_clear1", OP_CLEAR, 1'b0, 1'b0, LS, 1'b0, VFY);
    issue("t3_read1", OP_READ, 1'b0, 1'b0, LR, 1'b0, 1'b1);
    bad1 = 1'b0;

    // 4: CMD_VLD held across a busy WRITE with changing CMD_D/CMD_CH
    bus_if.cmd_op  = OP_WRITE;
    bus_if.cmd_ch  = 1'b0;
    bus_if.cmd_d   = 1'b0;
    bus_if.cmd_vld = 1'b1;
    tick();
    for (int c = 1; c <= LW; c++) begin
      bus_if.cmd_d  = ~bus_if.cmd_d;
      bus_if.cmd_ch = ~bus_if.cmd_ch;
      chk("t4_d1", d1, 1'b0);
      chk("t4_d2", d2, 1'b0);
      chk("t4_rsp_vld", bus_if.rsp_vld, (c == LW));
      if (c == 2) chk("t4_busy_rdy", bus_if.cmd_rdy, 1'b0);
      if (c == LW) begin
        chk("t4_rsp_q", bus_if.rsp_q, 1'b0);
        bus_if.cmd_vld = 1'b0;
      end
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      chk("t4_no_extra_rsp", bus_if.rsp_vld, 1'b0);
      chk("t4_d1_idle", d1, 1'b0);
      tick();
    end
    chk("t4_rdy", bus_if.cmd_rdy, 1'b1);

    // 5: reset during PULSE of a WRITE
    send(OP_WRITE, 1'b0, 1'b1);
    tick();
    tick();
    chk("t5_cp1_pulse", cp1, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_rst_pins", {4'b0, d1, cp1, sd1n, rd1n}, 8'b0000_0011);
    chk("t5_rst_rsp_vld", bus_if.rsp_vld, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("t5_rdy", bus_if.cmd_rdy, 1'b1);
    for (int c = 0; c < 8; c++) begin
      chk("t5_no_rsp", bus_if.rsp_vld, 1'b0);
      tick();
    end

    // 6: WRITE D=1 with the model stuck at Q=0
    stuck1 = 1'b1;
    issue("t6_write1", OP_WRITE, 1'b0, 1'b1, LW, ~VFY, VFY);
    issue("t6_read1", OP_READ, 1'b0, 1'b0, LR, 1'b0, 1'b0);
    stuck1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
